// File: rtl/prbs_qpsk_source.sv
// prbs_qpsk_source: two independent PRBS9 generators (x^9+x^5+1) mapped to QPSK
// symbols, one symbol per SYM_DIV clocks with zero-order hold between strobes.
// A REF_DELAY-symbol delay line provides aligned reference bits for a
// downstream slicer/BER stage.
module prbs_qpsk_source #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned DATA_F    = 7,
  parameter int unsigned AMP       = 91,
  parameter logic [8:0]  SEED_I    = 9'h1FF,
  parameter logic [8:0]  SEED_Q    = 9'h0F5,
  parameter int unsigned SYM_DIV   = 1,
  parameter int unsigned REF_DELAY = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     reseed,
  output logic signed [DWIDTH-1:0] Out_I,
  output logic signed [DWIDTH-1:0] Out_Q,
  output logic                     sym_valid,
  output logic                     ref_bit_I,
  output logic                     ref_bit_Q,
  output logic                     ref_valid,
  output logic                     busy,
  output logic [15:0]              sym_cnt
);

  if (AMP == 0 || AMP >= (32'd1 << (DWIDTH - 1)) || DATA_F >= DWIDTH ||
      SYM_DIV < 1 || SYM_DIV > 256 || REF_DELAY > 31) begin : g_param_check
    $error("prbs_qpsk_source: illegal parameter set");
  end

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [8:0] SEED_I_EFF = (SEED_I == 9'd0) ? 9'h1FF : SEED_I;
  localparam logic [8:0] SEED_Q_EFF = (SEED_Q == 9'd0) ? 9'h1FF : SEED_Q;

  localparam logic [DWIDTH-1:0] POS_AMP = DWIDTH'(AMP);
  localparam logic [DWIDTH-1:0] NEG_AMP = -POS_AMP;

  localparam logic [7:0]  DIV_LAST   = 8'(SYM_DIV - 1);
  localparam logic [4:0]  DRAIN_LAST = 5'(REF_DELAY - 1);
  // Keep one dummy entry when REF_DELAY == 0 so the line stays legal; it is
  // never shifted in that configuration.
  localparam int unsigned LINE_LEN   = (REF_DELAY == 0) ? 1 : REF_DELAY;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 div_cnt_q, div_cnt_d;
  logic [4:0]                 drain_cnt_q, drain_cnt_d;
  logic [8:0]                 lfsr_i_q, lfsr_i_d;
  logic [8:0]                 lfsr_q_q, lfsr_q_d;
  logic [DWIDTH-1:0]          out_i_q, out_i_d;
  logic [DWIDTH-1:0]          out_q_q, out_q_d;
  logic                       sym_valid_q, sym_valid_d;
  logic                       ref_bit_i_q, ref_bit_i_d;
  logic                       ref_bit_q_q, ref_bit_q_d;
  logic                       ref_valid_q, ref_valid_d;
  logic [15:0]                sym_cnt_q, sym_cnt_d;
  // Each entry is {bit_I, bit_Q, valid}; entry LINE_LEN-1 is the tail.
  logic [LINE_LEN-1:0][2:0]   line_q, line_d;

  logic                       strobe;
  logic [7:0]                 div_next;
  logic [2:0]                 tail;
  logic [2:0]                 shift_in;
  logic                       do_shift;

  function automatic logic [DWIDTH-1:0] map_bit(input logic b);
    return b ? NEG_AMP : POS_AMP;
  endfunction

  // Next-state, symbol generation and reference delay-line control.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    drain_cnt_d = drain_cnt_q;
    lfsr_i_d    = lfsr_i_q;
    lfsr_q_d    = lfsr_q_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    sym_valid_d = 1'b0;
    ref_valid_d = 1'b0;
    ref_bit_i_d = ref_bit_i_q;
    ref_bit_q_d = ref_bit_q_q;
    sym_cnt_d   = sym_cnt_q;
    line_d      = line_q;
    shift_in    = '0;
    do_shift    = 1'b0;

    strobe   = (div_cnt_q == '0);
    div_next = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 8'd1;
    tail     = line_q[LINE_LEN-1];

    unique case (state_q)
      ST_IDLE: begin
        out_i_d   = '0;
        out_q_d   = '0;
        div_cnt_d = '0;
        if (reseed) begin
          lfsr_i_d  = SEED_I_EFF;
          lfsr_q_d  = SEED_Q_EFF;
          sym_cnt_d = '0;
        end
        if (en) begin
          state_d = ST_RUN;
          line_d  = '0;
        end
      end

      ST_RUN: begin
        if (!en) begin
          // The strobe that would fall on this edge is suppressed.
          out_i_d     = '0;
          out_q_d     = '0;
          div_cnt_d   = '0;
          drain_cnt_d = '0;
          state_d     = (REF_DELAY == 0) ? ST_IDLE : ST_DRAIN;
        end else begin
          div_cnt_d = div_next;
          if (strobe) begin
            lfsr_i_d    = {lfsr_i_q[7:0], lfsr_i_q[8] ^ lfsr_i_q[4]};
            lfsr_q_d    = {lfsr_q_q[7:0], lfsr_q_q[8] ^ lfsr_q_q[4]};
            out_i_d     = map_bit(lfsr_i_q[8]);
            out_q_d     = map_bit(lfsr_q_q[8]);
            sym_valid_d = 1'b1;
            sym_cnt_d   = sym_cnt_q + 16'd1;
            if (REF_DELAY == 0) begin
              ref_bit_i_d = lfsr_i_q[8];
              ref_bit_q_d = lfsr_q_q[8];
              ref_valid_d = 1'b1;
            end else begin
              ref_bit_i_d = tail[2];
              ref_bit_q_d = tail[1];
              ref_valid_d = tail[0];
              shift_in    = {lfsr_i_q[8], lfsr_q_q[8], 1'b1};
              do_shift    = 1'b1;
            end
          end
        end
      end

      ST_DRAIN: begin
        out_i_d   = '0;
        out_q_d   = '0;
        div_cnt_d = div_next;
        if (strobe) begin
          ref_bit_i_d = tail[2];
          ref_bit_q_d = tail[1];
          ref_valid_d = tail[0];
          shift_in    = '0;
          do_shift    = 1'b1;
          drain_cnt_d = drain_cnt_q + 5'd1;
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d   = ST_IDLE;
            div_cnt_d = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (do_shift) begin
      line_d[0] = shift_in;
      for (int unsigned i = 1; i < LINE_LEN; i++) begin
        line_d[i] = line_q[i-1];
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      drain_cnt_q <= '0;
      lfsr_i_q    <= SEED_I_EFF;
      lfsr_q_q    <= SEED_Q_EFF;
      out_i_q     <= '0;
      out_q_q     <= '0;
      sym_valid_q <= 1'b0;
      ref_bit_i_q <= 1'b0;
      ref_bit_q_q <= 1'b0;
      ref_valid_q <= 1'b0;
      sym_cnt_q   <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      lfsr_i_q    <= lfsr_i_d;
      lfsr_q_q    <= lfsr_q_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      sym_valid_q <= sym_valid_d;
      ref_bit_i_q <= ref_bit_i_d;
      ref_bit_q_q <= ref_bit_q_d;
      ref_valid_q <= ref_valid_d;
      sym_cnt_q   <= sym_cnt_d;
      line_q      <= line_d;
    end
  end

  assign Out_I     = out_i_q;
  assign Out_Q     = out_q_q;
  assign sym_valid = sym_valid_q;
  assign ref_bit_I = ref_bit_i_q;
  assign ref_bit_Q = ref_bit_q_q;
  assign ref_valid = ref_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_prbs_qpsk_source.sv
// Directed bench for prbs_qpsk_source: one instance at SYM_DIV=1 (start,
// period, wrap) and one at SYM_DIV=4 (divider, reference delay, drain,
// resume/reseed, async reset).
module tb_prbs_qpsk_source;

  logic clk = 1'b0;
  logic rst;
  logic en1, en4, reseed1, reseed4;

  logic [15:0] o_i1, o_q1, o_i4, o_q4, cnt1, cnt4;
  logic        sv1, rbi1, rbq1, rv1, busy1;
  logic        sv4, rbi4, rbq4, rv4, busy4;

  int checks = 0;
  int errors = 0;

  logic bi [0:510];
  logic bq [0:510];
  logic [15:0] q_hand [0:8];
  logic [8:0]  s;
  int          refs;

  always #5 clk = ~clk;

  prbs_qpsk_source #(.DWIDTH(16), .DATA_F(7), .AMP(91), .SEED_I(9'h1FF),
                     .SEED_Q(9'h0F5), .SYM_DIV(1), .REF_DELAY(8)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .reseed(reseed1),
    .Out_I(o_i1), .Out_Q(o_q1), .sym_valid(sv1), .ref_bit_I(rbi1),
    .ref_bit_Q(rbq1), .ref_valid(rv1), .busy(busy1), .sym_cnt(cnt1));

  prbs_qpsk_source #(.DWIDTH(16), .DATA_F(7), .AMP(91), .SEED_I(9'h1FF),
                     .SEED_Q(9'h0F5), .SYM_DIV(4), .REF_DELAY(8)) u_dut4 (
    .clk(clk), .rst(rst), .en(en4), .reseed(reseed4),
    .Out_I(o_i4), .Out_Q(o_q4), .sym_valid(sv4), .ref_bit_I(rbi4),
    .ref_bit_Q(rbq4), .ref_valid(rv4), .busy(busy4), .sym_cnt(cnt4));

  function automatic logic [15:0] amp_of(input logic b);
    return b ? 16'hFFA5 : 16'h005B;   // -91 : +91
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    s = 9'h1FF;
    for (int n = 0; n < 511; n++) begin
      bi[n] = s[8];
      s = {s[7:0], s[8] ^ s[4]};
    end
    s = 9'h0F5;
    for (int n = 0; n < 511; n++) begin
      bq[n] = s[8];
      s = {s[7:0], s[8] ^ s[4]};
    end
    q_hand = '{16'h005B, 16'hFFA5, 16'hFFA5, 16'hFFA5, 16'hFFA5,
               16'h005B, 16'hFFA5, 16'h005B, 16'hFFA5};

    rst = 1'b1; en1 = 1'b0; en4 = 1'b0; reseed1 = 1'b0; reseed4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_i", 32'(o_i1), 32'h0);
    chk("rst_out_q", 32'(o_q1), 32'h0);
    chk("rst_sym_valid", 32'(sv1), 32'h0);
    chk("rst_ref_valid", 32'(rv1), 32'h0);
    chk("rst_ref_bits", 32'({rbi1, rbq1}), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_sym_cnt", 32'(cnt1), 32'h0);
    chk("rst_busy4", 32'(busy4), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Start with SYM_DIV=1, then period check and sym_cnt wrap.
    en1 = 1'b1;
    @(negedge clk);
    chk("start_busy", 32'(busy1), 32'h1);
    chk("start_no_sv", 32'(sv1), 32'h0);
    for (int n = 0; n < 65536; n++) begin
      @(negedge clk);
      if (n < 9) begin
        chk("hand_i", 32'(o_i1), 32'hFFA5);
        chk("hand_q", 32'(o_q1), 32'(q_hand[n]));
      end
      if (n < 1022) begin
        chk("cont_sv", 32'(sv1), 32'h1);
        chk("seq_i", 32'(o_i1), 32'(amp_of(bi[n % 511])));
        chk("seq_q", 32'(o_q1), 32'(amp_of(bq[n % 511])));
      end
      if (n == 1021)  chk("cnt_1022", 32'(cnt1), 32'd1022);
      if (n == 65534) chk("cnt_max", 32'(cnt1), 32'd65535);
      if (n == 65535) chk("cnt_wrap", 32'(cnt1), 32'd0);
    end
    en1 = 1'b0;

    // Divider and reference alignment with SYM_DIV=4, REF_DELAY=8.
    en4 = 1'b1;
    @(negedge clk);
    chk("div_busy", 32'(busy4), 32'h1);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      chk("div_sv", 32'(sv4), 32'((c % 4) == 0));
      chk("div_out_i", 32'(o_i4), 32'(amp_of(bi[c / 4])));
      chk("div_out_q", 32'(o_q4), 32'(amp_of(bq[c / 4])));
      chk("div_rv", 32'(rv4), 32'(((c % 4) == 0) && (c / 4 >= 8)));
      if (((c % 4) == 0) && (c / 4 >= 8)) begin
        chk("ref_bit_i", 32'(rbi4), 32'(bi[c / 4 - 8]));
        chk("ref_bit_q", 32'(rbq4), 32'(bq[c / 4 - 8]));
      end
      if (c == 32) chk("first_ref_i", 32'(rbi4), 32'h1);
    end

    // Stop on the edge that would otherwise strobe symbol 20, then drain.
    en4 = 1'b0;
    @(negedge clk);
    chk("stop_out_i", 32'(o_i4), 32'h0);
    chk("stop_out_q", 32'(o_q4), 32'h0);
    chk("stop_sv", 32'(sv4), 32'h0);
    chk("stop_busy", 32'(busy4), 32'h1);
    chk("stop_cnt", 32'(cnt4), 32'd20);
    refs = 0;
    for (int c = 0; c < 60 && busy4; c++) begin
      @(negedge clk);
      chk("drain_out", 32'(o_i4), 32'h0);
      chk("drain_sv", 32'(sv4), 32'h0);
      if (rv4) begin
        if (refs < 8) begin
          chk("drain_ref_i", 32'(rbi4), 32'(bi[12 + refs]));
          chk("drain_ref_q", 32'(rbq4), 32'(bq[12 + refs]));
        end
        refs++;
      end
    end
    chk("drain_refs", 32'(refs), 32'd8);
    chk("drain_busy", 32'(busy4), 32'h0);
    chk("drain_cnt", 32'(cnt4), 32'd20);
    chk("drain_last_i", 32'(rbi4), 32'(bi[19]));
    chk("drain_last_q", 32'(rbq4), 32'(bq[19]));

    // Resume continues the sequence; reseed while busy is ignored.
    en4 = 1'b1;
    repeat (2) @(negedge clk);
    chk("resume_sv", 32'(sv4), 32'h1);
    chk("resume_i", 32'(o_i4), 32'(amp_of(bi[20])));
    chk("resume_q", 32'(o_q4), 32'(amp_of(bq[20])));
    chk("resume_cnt", 32'(cnt4), 32'd21);
    chk("resume_rv", 32'(rv4), 32'h0);
    reseed4 = 1'b1;
    @(negedge clk);
    reseed4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_reseed_sv", 32'(sv4), 32'h1);
    chk("busy_reseed_i", 32'(o_i4), 32'(amp_of(bi[21])));
    chk("busy_reseed_q", 32'(o_q4), 32'(amp_of(bq[21])));
    chk("busy_reseed_cnt", 32'(cnt4), 32'd22);
    en4 = 1'b0;
    for (int c = 0; c < 60 && busy4; c++) @(negedge clk);
    chk("idle_busy", 32'(busy4), 32'h0);
    chk("idle_cnt", 32'(cnt4), 32'd22);

    // Reseed in IDLE restarts at symbol 0.
    reseed4 = 1'b1;
    @(negedge clk);
    reseed4 = 1'b0;
    chk("reseed_cnt", 32'(cnt4), 32'd0);
    en4 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reseed_sv", 32'(sv4), 32'h1);
    chk("reseed_i", 32'(o_i4), 32'hFFA5);
    chk("reseed_q", 32'(o_q4), 32'h005B);
    chk("reseed_cnt1", 32'(cnt4), 32'd1);

    // Asynchronous reset mid-symbol, checked before any further clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_i", 32'(o_i4), 32'h0);
    chk("arst_out_q", 32'(o_q4), 32'h0);
    chk("arst_sv", 32'(sv4), 32'h0);
    chk("arst_rv", 32'(rv4), 32'h0);
    chk("arst_ref_bits", 32'({rbi4, rbq4}), 32'h0);
    chk("arst_busy", 32'(busy4), 32'h0);
    chk("arst_cnt", 32'(cnt4), 32'h0);
    en4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
